// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: unsigned WIDTH-bit ripple-carry adder with registered WIDTH+1-bit sum (define RCA_COMB_OUT_EN for a combinational output)
module rca_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic [WIDTH:0]   sum
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   sum_d;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        rca_full_adder u_fa (
            .a_i(num1[i]),
            .b_i(num2[i]),
            .c_i(c[i]),
            .s_o(s[i]),
            .c_o(c[i+1])
        );
    end
    assign sum_d = {c[WIDTH], s};
`ifdef RCA_COMB_OUT_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign sum = sum_d;
`else
    logic [WIDTH:0] sum_q;
    // result register; reset clears it immediately and discards any pending sum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end
    assign sum = sum_q;
`endif
endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: randomized and directed checks of ripple_carry_adder against an arithmetic model
`timescale 1ns/1ps
module tb_ripple_carry_adder;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] num1 = '0;
    logic [W-1:0] num2 = '0;
    logic [W:0]   sum;
    logic [W:0]   exp_q = '0;
    logic [W-1:0] sa, sb;
    int n_chk = 0;
    int n_pass = 0;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .num1(num1),
        .num2(num2),
        .sum(sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        num1 = a;
        num2 = b;
        #2 check({tag, "_hold"}, sum, exp_q);
        @(posedge clk);
        #1 check(tag, sum, ref_add(a, b));
        exp_q = ref_add(a, b);
    endtask

    task automatic bump();
        num1 = num1 + 1'b1;
        if (num1[3:0] == 4'hF) num2 = num2 + 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        num1 = 8'hAA;
        num2 = 8'h55;
        #1 check("reset_async", sum, 9'h000);
        #2 reset = 1'b0;
        @(posedge clk);
        #1 check("reset_release", sum, 9'h0FF);
        exp_q = 9'h0FF;
        step("zero", 8'h00, 8'h00);
        step("no_carry", 8'h0F, 8'h10);
        step("carry_chain", 8'hFF, 8'h01);
        step("all_ones", 8'hFF, 8'hFF);
        step("lat_a", 8'd3, 8'd4);
        step("lat_b", 8'd100, 8'd200);
        repeat (200) step("rand", W'($urandom), W'($urandom));
        @(negedge clk);
        num1 = 8'h80;
        num2 = 8'h80;
        #2 reset = 1'b1;
        #1 check("mid_reset", sum, 9'h000);
        reset = 1'b0;
        @(posedge clk);
        #1 check("mid_reset_release", sum, 9'h100);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            sa = num1;
            sb = num2;
            #1 check("sweep", sum, ref_add(sa, sb));
            #1.5 bump();
            @(negedge clk);
            #2.5 bump();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
